// File: rtl/m1_rst_pkg.sv
// Shared definitions for the Cortex-M1 reset controller: cause codes,
// FSM state encoding and the lockup counter width.
package m1_rst_pkg;

  typedef enum logic [1:0] {
    CAUSE_POR    = 2'd0,
    CAUSE_SW     = 2'd1,
    CAUSE_LOCKUP = 2'd2
  } cause_e;

  typedef enum logic {
    ST_ASSERT = 1'b0,
    ST_RUN    = 1'b1
  } state_e;

  localparam int LOCKUP_CNT_W = 16;

endpackage

// File: rtl/m1_rst_ctrl_rst_sync.sv
// Two-flop reset synchronizer: asynchronous assertion, deassertion on the
// second rising clock edge after arst_n is released.
module rst_sync (
  input  logic clk,
  input  logic arst_n,
  output logic sync_rstn
);

  logic [1:0] sync_r;

  // Shift a constant one through two flops once reset is released
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sync_r <= 2'b00;
    end else begin
      sync_r <= {sync_r[0], 1'b1};
    end
  end

  assign sync_rstn = sync_r[1];

endmodule

// File: rtl/m1_rst_ctrl.sv
// Reset controller for the Cortex-M1 core: POR, software and (optionally)
// lockup resets. Lockup auto-reset is built only with M1_RST_LOCKUP_AUTO_EN.
module m1_rst_ctrl
  import m1_rst_pkg::*;
#(
  parameter int HOLD_CYCLES   = 16,
  parameter int LOCKUP_FILTER = 256
) (
  input  logic       HCLK,
  input  logic       hwRstn,
  input  logic       LOCKUP,
  input  logic       HALTED,
  input  logic       sw_rst_req,
  output logic       core_rstn,
  output logic [1:0] rst_cause,
  output logic [7:0] rst_count
);

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  logic       sync_rstn;
  state_e     state_r;
  state_e     state_nxt;
  logic [7:0] hold_cnt_r;
  logic [7:0] hold_cnt_nxt;
  cause_e     cause_r;
  logic [7:0] count_r;
  logic       core_rstn_r;
  logic       sw_fire_s;
  logic       lock_fire_s;

  rst_sync u_rst_sync (
    .clk       (HCLK),
    .arst_n    (hwRstn),
    .sync_rstn (sync_rstn)
  );

  assign sw_fire_s = (state_r == ST_RUN) && sw_rst_req;

`ifdef M1_RST_LOCKUP_AUTO_EN
  localparam logic [LOCKUP_CNT_W-1:0] LOCK_LAST = LOCKUP_CNT_W'(LOCKUP_FILTER - 1);

  logic [LOCKUP_CNT_W-1:0] lock_cnt_r;

  assign lock_fire_s = (state_r == ST_RUN) && LOCKUP && !HALTED && (lock_cnt_r == LOCK_LAST);

  // Lockup filter: counts unhalted lockup cycles, frozen while halted
  always_ff @(posedge HCLK or negedge sync_rstn) begin
    if (!sync_rstn) begin
      lock_cnt_r <= '0;
    end else if ((state_r != ST_RUN) || sw_fire_s || lock_fire_s || !LOCKUP) begin
      lock_cnt_r <= '0;
    end else if (HALTED) begin
      lock_cnt_r <= lock_cnt_r;
    end else begin
      lock_cnt_r <= lock_cnt_r + 16'd1;
    end
  end
`else
  logic unused_lockup;
  assign unused_lockup = LOCKUP ^ HALTED ^ (LOCKUP_FILTER > 0);
  assign lock_fire_s   = 1'b0;
`endif

  // Next-state logic for the hold sequence
  always_comb begin
    state_nxt    = state_r;
    hold_cnt_nxt = hold_cnt_r;
    case (state_r)
      ST_ASSERT: begin
        if (hold_cnt_r == HOLD_LAST) begin
          state_nxt    = ST_RUN;
          hold_cnt_nxt = 8'd0;
        end else begin
          hold_cnt_nxt = hold_cnt_r + 8'd1;
        end
      end
      ST_RUN: begin
        if (sw_fire_s || lock_fire_s) begin
          state_nxt    = ST_ASSERT;
          hold_cnt_nxt = 8'd0;
        end else begin
          hold_cnt_nxt = 8'd0;
        end
      end
      default: begin
        state_nxt    = ST_ASSERT;
        hold_cnt_nxt = 8'd0;
      end
    endcase
  end

  // State, hold counter and the registered core reset
  always_ff @(posedge HCLK or negedge sync_rstn) begin
    if (!sync_rstn) begin
      state_r     <= ST_ASSERT;
      hold_cnt_r  <= 8'd0;
      core_rstn_r <= 1'b0;
    end else begin
      state_r     <= state_nxt;
      hold_cnt_r  <= hold_cnt_nxt;
      core_rstn_r <= (state_nxt == ST_RUN);
    end
  end

  // Cause and saturating count; software wins a tie with lockup
  always_ff @(posedge HCLK or negedge sync_rstn) begin
    if (!sync_rstn) begin
      cause_r <= CAUSE_POR;
      count_r <= 8'd0;
    end else begin
      if (sw_fire_s) begin
        cause_r <= CAUSE_SW;
      end else if (lock_fire_s) begin
        cause_r <= CAUSE_LOCKUP;
      end else begin
        cause_r <= cause_r;
      end
      if ((sw_fire_s || lock_fire_s) && (count_r != 8'hFF)) begin
        count_r <= count_r + 8'd1;
      end else begin
        count_r <= count_r;
      end
    end
  end

  assign core_rstn = core_rstn_r;
  assign rst_cause = cause_r;
  assign rst_count = count_r;

endmodule

// File: doc/m1_rst_ctrl.md
M1_RST_CTRL -- requirements
Module: m1_rst_ctrl

Interface
REQ-001 The block SHALL have parameter HOLD_CYCLES, default 16, giving the number of HCLK cycles core_rstn is held low per reset event (legal 1..255).
REQ-002 The block SHALL have parameter LOCKUP_FILTER, default 256, giving the number of consecutive LOCKUP-high cycles that count as a lockup event (legal 1..65535).
REQ-003 The block SHALL have port HCLK, input, 1 bit: the single clock, shared with the M1 core.
REQ-004 The block SHALL have port hwRstn, input, 1 bit: board reset, asynchronous, active-low.
REQ-005 The block SHALL have port LOCKUP, input, 1 bit: core lockup status, synchronous to HCLK.
REQ-006 The block SHALL have port HALTED, input, 1 bit: core debug-halt status, synchronous to HCLK.
REQ-007 The block SHALL have port sw_rst_req, input, 1 bit: software reset request from GPIO, a single-cycle pulse synchronous to HCLK.
REQ-008 The block SHALL have port core_rstn, output, 1 bit: registered active-low reset driving the core's hwRstn.
REQ-009 The block SHALL have port rst_cause, output, 2 bits: cause of the last reset (0 POR, 1 SW, 2 LOCKUP).
REQ-010 The block SHALL have port rst_count, output, 8 bits: number of non-POR resets, saturating.

Function
REQ-011 The block SHALL use an FSM with states ASSERT (core_rstn=0, hold counter running) and RUN (core_rstn=1).
REQ-012 The block SHALL, in ASSERT, count HCLK cycles and enter RUN on the cycle the count reaches HOLD_CYCLES-1, so that core_rstn is low for exactly HOLD_CYCLES cycles.
REQ-013 The block SHALL, in RUN, on sw_rst_req=1, enter ASSERT on the next edge, set rst_cause=1 and increment rst_count.
REQ-014 The block SHALL, in RUN, increment a 16-bit lockup counter each cycle LOCKUP=1 and HALTED=0, freeze it while HALTED=1, and clear it whenever LOCKUP=0.
REQ-015 The block SHALL raise a lockup event when the lockup counter reaches LOCKUP_FILTER-1 with LOCKUP=1 and HALTED=0.
REQ-016 The block SHALL, when sw_rst_req and a lockup event coincide, apply SW priority: rst_cause=1, and rst_count increments by one only.
REQ-017 The block SHALL ignore sw_rst_req and LOCKUP while in ASSERT, and SHALL clear the lockup counter on entry to ASSERT.
REQ-018 The block SHALL hold rst_count at 255 once it reaches 255 (no wrap).
REQ-019 The block SHALL never let a request made during ASSERT extend the hold period.

Reset
REQ-020 The block SHALL pass hwRstn through a two-flop synchronizer: assertion asynchronous, deassertion on the 2nd HCLK rising edge.
REQ-021 The block SHALL, while hwRstn is low, force core_rstn=0, rst_cause=0, rst_count=0, the lockup counter to 0 and the FSM to ASSERT, all asynchronously.
REQ-022 After hwRstn rises, the block SHALL drive core_rstn high exactly HOLD_CYCLES+2 HCLK edges later.
REQ-023 The block SHALL, if hwRstn asserts mid-ASSERT or mid-RUN, abort immediately and restart the POR sequence.
REQ-024 rst_cause and rst_count SHALL be cleared only by hwRstn, never by SW or LOCKUP resets.

Configuration
REQ-025 With macro M1_RST_LOCKUP_AUTO_EN defined, the block SHALL reset the core on a lockup event per REQ-015, setting rst_cause=2 and incrementing rst_count.
REQ-026 Without M1_RST_LOCKUP_AUTO_EN, the block SHALL omit the lockup counter logic, SHALL treat LOCKUP as unused, and SHALL never produce rst_cause=2.

Structure
REQ-027 The shared package m1_rst_pkg SHALL hold the cause codes CAUSE_POR/CAUSE_SW/CAUSE_LOCKUP, the FSM state encoding and the 16-bit lockup counter width constant.
REQ-028 The synchronizer SHALL be a sub-module named rst_sync, instantiated once.

Verification
REQ-029 The bench SHALL cover POR: hwRstn low 5 cycles then high, HOLD_CYCLES=16 -> core_rstn rises at edge 18 after release, rst_cause=0, rst_count=0.
REQ-030 The bench SHALL cover SW reset: sw_rst_req pulse in RUN -> core_rstn low for 16 cycles starting next edge, rst_cause=1, rst_count=1.
REQ-031 The bench SHALL cover lockup (macro on, LOCKUP_FILTER=8): LOCKUP high 8 cycles -> reset, rst_cause=2; LOCKUP high 7 cycles then low -> no reset.
REQ-032 The bench SHALL cover halt freeze: LOCKUP high 4 cycles, HALTED high 20 cycles, then 4 more lockup cycles -> reset occurs only after the 8th unhalted lockup cycle.
REQ-033 The bench SHALL cover coincidence and saturation: sw_rst_req on the lockup-event cycle -> rst_cause=1 and count+1; 300 SW resets -> rst_count=255.
REQ-034 The bench SHALL cover mid-sequence POR: hwRstn pulsed low during ASSERT -> core_rstn stays low, and rst_cause and rst_count return to 0.
